rename_map_table: RTL and testbench
===================================

# rename_map_table

Parametrised register mapping table for the rename stage: translates WIDTH source/destination triples per cycle to physical tags, with intra-group bypass. Holds an internal ring of NUM_CKPT map snapshots for branch checkpoints, restored by tag on mispredict and retired in order on correct resolution. Sits between decode and the free list / issue queues. It replaces the external-snapshot two-wide table with an owned, tagged checkpoint store, x0 hardwiring and full-checkpoint back-pressure.

## Interface
- WIDTH, 2, rename slots per cycle (slot 0 oldest)
- NUM_ARCH, 32, architectural registers
- NUM_PHYS, 64, physical registers; tags are clog2(NUM_PHYS) bits
- NUM_CKPT, 4, checkpoint slots; power of two; tags are clog2(NUM_CKPT) bits

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  external stall; no state update from rename
- valid_instr  in  [WIDTH]x1  slot holds an instruction
- rs1, rs2, rd  in  [WIDTH]xclog2(NUM_ARCH)  architectural indices
- rd_we  in  [WIDTH]x1  slot writes rd
- phys_rd  in  [WIDTH]xphys tag  new tag from free list
- ckpt_req  in  [WIDTH]x1  slot is a branch needing a checkpoint; at most one set per cycle
- resolve_valid, resolve_tag  in  1, ckpt tag  branch resolved correctly
- recall_valid, recall_tag  in  1, ckpt tag  branch mispredicted; restore its snapshot
- phys_rs1, phys_rs2, old_rd  out  [WIDTH]xphys tag  mappings
- ckpt_tag  out  ckpt tag  tag assigned to this cycle's checkpoint (= tail)
- ckpt_full  out  1  count == NUM_CKPT
- rename_ready  out  1  group accepted this cycle

## Operation
- Effective write of slot k: we_k = valid_instr[k] && rd_we[k] && rd[k] != 0.
- Slot j lookups: map value, overridden by youngest slot k<j with we_k and matching index. old_rd uses the same rule. Reads of x0 always return 0.
- rename_ready = !recall_valid && !(|(ckpt_req & valid_instr) && ckpt_full). Group is all-or-nothing. Map and checkpoint updates happen only when rename_ready && !stall.
- Map update: for each arch reg, the youngest slot writing it wins. map[0] stays 0 permanently.
- Checkpoint at slot k: snapshot = map after applying writes of slots 0..k only. It is written to ring[tail], marked valid and unresolved. Then tail++ and count++.
- Resolve: set resolved[resolve_tag] if the entry is valid. Each cycle, if valid[head] && resolved[head], clear valid and do head++ and count--. This retires at most one entry per cycle.
- Recall tag T, where T must be valid:
  - map <= ring[T].
  - Invalidate entries T through tail-1.
  - tail <= T.
  - count <= (T - head) mod NUM_CKPT.
- Recall has priority over rename. Resolve is applied in the same cycle; if it targets an entry discarded by the recall, it has no effect. A head retirement in the same cycle as a recall is applied first, and the recall count is computed from the updated head.
- Allocation and retirement in the same cycle leave count unchanged. Pointers wrap modulo NUM_CKPT.
- A recall or resolve naming an invalid tag is illegal and must fire an assertion. A recall naming an invalid tag leaves state unchanged.

## Timing
- Lookups, ckpt_tag, ckpt_full and rename_ready are combinational in the same cycle.
- Map and ring state update at the next posedge. A recall is visible to lookups one cycle after recall_valid.
- Reset values:
  - map[i] = i.
  - head = tail = count = 0; all valid and resolved bits 0.
  - ckpt_full = 0; rename_ready = 1 when no recall is presented.
- reset overrides all other inputs, including recall mid-operation.

## Structure
- Package rename_pkg holds:
  - arch_reg_t, phys_reg_t, ckpt_tag_t;
  - map_t (array[NUM_ARCH] of phys_reg_t);
  - default parameter constants.
- Sub-module rmt_ckpt_ring holds ring storage, the valid and resolved bits, head/tail/count, the retirement logic and recall truncation. The top module keeps the map, the bypass and the snapshot-composition logic.

## Test plan
- Reset, then read rs1 = 5, rs2 = 31 -> phys 5, 31; ckpt_full = 0; rename_ready = 1.
- Group rd[0] = rd[1] = 3, phys 40/41, rs1[1] = 3 -> phys_rs1[1] = 40, old_rd[1] = 40; next cycle map[3] = 41.
- Slot 0 writes x0 with phys 50 -> map[0] stays 0; later reads of x0 return 0.
- ckpt_req[0] with rd[0] = 7 -> 42 and slot 1 rd = 7 -> 43, tag 0. Then 3 further checkpoints -> ckpt_full = 1, and a fifth request drops rename_ready with no state change. Recall tag 0 -> map[7] = 42, count = 0, next ckpt_tag = 0.
- 4 checkpoints with tags 0-3. Resolve tag 1, then tag 0 -> head reaches 2 after two cycles and count = 2. Recall tag 3 -> count = 1, tail = 3.
- recall_valid and resolve of a discarded tag in the same cycle, with rename valid -> rename_ready = 0, the resolve is ignored, and the map equals the recalled snapshot.

Source files
------------

// File: rtl/rename_map_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_pkg
// Description : Shared types and default sizing for the rename map table.
// Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int c_WIDTH    = 2;
    localparam int c_NUM_ARCH = 32;
    localparam int c_NUM_PHYS = 64;
    localparam int c_NUM_CKPT = 4;

    localparam int c_ARCH_W = $clog2(c_NUM_ARCH);
    localparam int c_PHYS_W = $clog2(c_NUM_PHYS);
    localparam int c_CKPT_W = $clog2(c_NUM_CKPT);

    typedef logic [c_ARCH_W-1:0] arch_reg_t;
    typedef logic [c_PHYS_W-1:0] phys_reg_t;
    typedef logic [c_CKPT_W-1:0] ckpt_tag_t;
    typedef phys_reg_t [c_NUM_ARCH-1:0] map_t;

endpackage
`default_nettype wire

// File: rtl/rename_map_table_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_map_table_if
// Description : Rename-group request/response and branch-resolution bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_map_table_if
    import rename_pkg::*;
#(
    parameter int WIDTH    = c_WIDTH,
    parameter int NUM_ARCH = c_NUM_ARCH,
    parameter int NUM_PHYS = c_NUM_PHYS,
    parameter int NUM_CKPT = c_NUM_CKPT
);
    localparam int c_AW = $clog2(NUM_ARCH);
    localparam int c_PW = $clog2(NUM_PHYS);
    localparam int c_TW = $clog2(NUM_CKPT);

    logic                        stall;
    logic [WIDTH-1:0]            valid_instr;
    logic [WIDTH-1:0][c_AW-1:0]  rs1;
    logic [WIDTH-1:0][c_AW-1:0]  rs2;
    logic [WIDTH-1:0][c_AW-1:0]  rd;
    logic [WIDTH-1:0]            rd_we;
    logic [WIDTH-1:0][c_PW-1:0]  phys_rd;
    logic [WIDTH-1:0]            ckpt_req;
    logic                        resolve_valid;
    logic [c_TW-1:0]             resolve_tag;
    logic                        recall_valid;
    logic [c_TW-1:0]             recall_tag;

    logic [WIDTH-1:0][c_PW-1:0]  phys_rs1;
    logic [WIDTH-1:0][c_PW-1:0]  phys_rs2;
    logic [WIDTH-1:0][c_PW-1:0]  old_rd;
    logic [c_TW-1:0]             ckpt_tag;
    logic                        ckpt_full;
    logic                        rename_ready;

    modport master (
        output stall, valid_instr, rs1, rs2, rd, rd_we, phys_rd, ckpt_req,
               resolve_valid, resolve_tag, recall_valid, recall_tag,
        input  phys_rs1, phys_rs2, old_rd, ckpt_tag, ckpt_full, rename_ready
    );

    modport slave (
        input  stall, valid_instr, rs1, rs2, rd, rd_we, phys_rd, ckpt_req,
               resolve_valid, resolve_tag, recall_valid, recall_tag,
        output phys_rs1, phys_rs2, old_rd, ckpt_tag, ckpt_full, rename_ready
    );

endinterface
`default_nettype wire

// File: rtl/rename_map_table_ckpt_ring.sv
`default_nettype none
// ============================================================================
// Module      : rmt_ckpt_ring
// Description : Tagged ring of map snapshots with in-order retirement and
//               recall truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module rmt_ckpt_ring
    import rename_pkg::*;
#(
    parameter int   NUM_ARCH = c_NUM_ARCH,
    parameter int   NUM_PHYS = c_NUM_PHYS,
    parameter int   NUM_CKPT = c_NUM_CKPT,
    localparam int  c_PW     = $clog2(NUM_PHYS),
    localparam int  c_TW     = $clog2(NUM_CKPT)
)
(
    input  wire                                 clk,
    input  wire                                 reset,
    input  wire                                 alloc,
    input  wire logic [NUM_ARCH-1:0][c_PW-1:0]  alloc_snap,
    input  wire                                 resolve_valid,
    input  wire logic [c_TW-1:0]                resolve_tag,
    input  wire                                 recall_valid,
    input  wire logic [c_TW-1:0]                recall_tag,
    output logic                                recall_ok,
    output logic [NUM_ARCH-1:0][c_PW-1:0]       recall_snap,
    output logic [c_TW-1:0]                     tail,
    output logic                                full
);

    logic [NUM_ARCH-1:0][c_PW-1:0] r_ring [NUM_CKPT];
    logic [NUM_CKPT-1:0]           r_valid;
    logic [NUM_CKPT-1:0]           r_resolved;
    logic [c_TW-1:0]               r_head;
    logic [c_TW-1:0]               r_tail;
    logic [c_TW:0]                 r_count;

    logic                          w_retire;
    logic                          w_recall_go;
    logic [c_TW:0]                 w_trunc_len;
    logic [NUM_CKPT-1:0]           w_trunc;
    logic [NUM_CKPT-1:0]           w_valid_nxt;
    logic [NUM_CKPT-1:0]           w_resolved_nxt;
    logic [c_TW-1:0]               w_head_nxt;
    logic [c_TW-1:0]               w_tail_nxt;
    logic [c_TW:0]                 w_count_nxt;

    assign w_retire    = r_valid[r_head] && r_resolved[r_head];
    assign recall_ok   = r_valid[recall_tag];
    assign w_recall_go = recall_valid && recall_ok;
    assign recall_snap = r_ring[recall_tag];
    assign tail        = r_tail;
    assign full        = (r_count == (c_TW+1)'(NUM_CKPT));

    // Entries recall_tag .. tail-1 are discarded; a zero distance means the
    // whole ring is live, since recall_tag itself must be valid.
    always_comb begin
        w_trunc_len = {1'b0, r_tail - recall_tag};
        if (w_trunc_len == '0) begin
            w_trunc_len = (c_TW+1)'(NUM_CKPT);
        end
        for (int i = 0; i < NUM_CKPT; i++) begin
            w_trunc[i] = ({1'b0, c_TW'(i) - recall_tag} < w_trunc_len);
        end
    end

    always_comb begin
        w_valid_nxt    = r_valid;
        w_resolved_nxt = r_resolved;
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;

        if (resolve_valid && r_valid[resolve_tag]) begin
            w_resolved_nxt[resolve_tag] = 1'b1;
        end

        if (w_retire) begin
            w_valid_nxt[r_head]    = 1'b0;
            w_resolved_nxt[r_head] = 1'b0;
            w_head_nxt             = r_head + c_TW'(1);
            w_count_nxt            = r_count - (c_TW+1)'(1);
        end

        // Recall sees the post-retirement head; its truncation also clears
        // any resolve aimed at a discarded entry.
        if (w_recall_go) begin
            w_valid_nxt    = w_valid_nxt & ~w_trunc;
            w_resolved_nxt = w_resolved_nxt & ~w_trunc;
            w_tail_nxt     = recall_tag;
            w_count_nxt    = {1'b0, recall_tag - w_head_nxt};
        end else if (alloc) begin
            w_valid_nxt[r_tail]    = 1'b1;
            w_resolved_nxt[r_tail] = 1'b0;
            w_tail_nxt             = r_tail + c_TW'(1);
            w_count_nxt            = w_count_nxt + (c_TW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= '0;
            r_resolved <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_resolved <= w_resolved_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc && !w_recall_go) begin
            r_ring[r_tail] <= alloc_snap;
        end
    end

    a_recall_tag_valid : assert property (@(posedge clk) disable iff (reset)
        recall_valid |-> r_valid[recall_tag]);

    a_resolve_tag_valid : assert property (@(posedge clk) disable iff (reset)
        resolve_valid |-> r_valid[resolve_tag]);

endmodule
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// ============================================================================
// Module      : rename_map_table
// Description : Multi-slot register rename map with intra-group bypass and
//               an owned ring of branch checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_map_table
    import rename_pkg::*;
#(
    parameter int WIDTH    = c_WIDTH,
    parameter int NUM_ARCH = c_NUM_ARCH,
    parameter int NUM_PHYS = c_NUM_PHYS,
    parameter int NUM_CKPT = c_NUM_CKPT
)
(
    input  wire                  clk,
    input  wire                  reset,
    rename_map_table_if.slave    bus
);

    localparam int c_PW = $clog2(NUM_PHYS);
    localparam int c_TW = $clog2(NUM_CKPT);

    logic [NUM_ARCH-1:0][c_PW-1:0] r_map;
    logic [NUM_ARCH-1:0][c_PW-1:0] w_map_next;
    logic [NUM_ARCH-1:0][c_PW-1:0] w_snap;
    logic [NUM_ARCH-1:0][c_PW-1:0] w_recall_snap;

    logic [WIDTH-1:0]              w_we;
    logic [WIDTH-1:0]              w_ckpt_slot;
    logic                          w_ckpt_any;
    logic                          w_ready;
    logic                          w_fire;
    logic                          w_alloc;
    logic                          w_recall_ok;
    logic                          w_full;
    logic [c_TW-1:0]               w_tail;

    logic [WIDTH-1:0][c_PW-1:0]    w_rs1;
    logic [WIDTH-1:0][c_PW-1:0]    w_rs2;
    logic [WIDTH-1:0][c_PW-1:0]    w_old;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_we[k] = bus.valid_instr[k] && bus.rd_we[k] && (bus.rd[k] != '0);
        end
    end

    assign w_ckpt_slot = bus.ckpt_req & bus.valid_instr;
    assign w_ckpt_any  = |w_ckpt_slot;
    assign w_ready     = !bus.recall_valid && !(w_ckpt_any && w_full);
    assign w_fire      = w_ready && !bus.stall;
    assign w_alloc     = w_fire && w_ckpt_any;

    // Older slots are scanned in order so the youngest earlier writer wins.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            w_rs1[j] = r_map[bus.rs1[j]];
            w_rs2[j] = r_map[bus.rs2[j]];
            w_old[j] = r_map[bus.rd[j]];
            for (int k = 0; k < j; k++) begin
                if (w_we[k] && (bus.rd[k] == bus.rs1[j])) w_rs1[j] = bus.phys_rd[k];
                if (w_we[k] && (bus.rd[k] == bus.rs2[j])) w_rs2[j] = bus.phys_rd[k];
                if (w_we[k] && (bus.rd[k] == bus.rd[j]))  w_old[j] = bus.phys_rd[k];
            end
            if (bus.rs1[j] == '0) w_rs1[j] = '0;
            if (bus.rs2[j] == '0) w_rs2[j] = '0;
            if (bus.rd[j]  == '0) w_old[j] = '0;
        end
    end

    // The snapshot is the running map captured right after the branch slot.
    always_comb begin
        w_map_next = r_map;
        w_snap     = r_map;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_we[k]) begin
                w_map_next[bus.rd[k]] = bus.phys_rd[k];
            end
            if (w_ckpt_slot[k]) begin
                w_snap = w_map_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                r_map[i] <= c_PW'(i);
            end
        end else if (bus.recall_valid) begin
            if (w_recall_ok) begin
                r_map <= w_recall_snap;
            end
        end else if (w_fire) begin
            r_map <= w_map_next;
        end
    end

    rmt_ckpt_ring #(
        .NUM_ARCH (NUM_ARCH),
        .NUM_PHYS (NUM_PHYS),
        .NUM_CKPT (NUM_CKPT)
    ) u_ckpt_ring (
        .clk           (clk),
        .reset         (reset),
        .alloc         (w_alloc),
        .alloc_snap    (w_snap),
        .resolve_valid (bus.resolve_valid),
        .resolve_tag   (bus.resolve_tag),
        .recall_valid  (bus.recall_valid),
        .recall_tag    (bus.recall_tag),
        .recall_ok     (w_recall_ok),
        .recall_snap   (w_recall_snap),
        .tail          (w_tail),
        .full          (w_full)
    );

    assign bus.phys_rs1     = w_rs1;
    assign bus.phys_rs2     = w_rs2;
    assign bus.old_rd       = w_old;
    assign bus.ckpt_tag     = w_tail;
    assign bus.ckpt_full    = w_full;
    assign bus.rename_ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_rename_map_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_map_table
// Description : Directed scoreboard bench for rename_map_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_map_table;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rename_map_table_if bus ();

    rename_map_table dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string                  name;
        bit                     chk_lookup;
        phys_reg_t [c_WIDTH-1:0] rs1;
        phys_reg_t [c_WIDTH-1:0] rs2;
        phys_reg_t [c_WIDTH-1:0] old;
        ckpt_tag_t              tag;
        bit                     full;
        bit                     rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each expectation is compared
    // mid-cycle against whatever the DUT presents.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_lookup) begin
                for (int j = 0; j < c_WIDTH; j++) begin
                    check($sformatf("%s.phys_rs1[%0d]", mon_e.name, j), 32'(bus.phys_rs1[j]), 32'(mon_e.rs1[j]));
                    check($sformatf("%s.phys_rs2[%0d]", mon_e.name, j), 32'(bus.phys_rs2[j]), 32'(mon_e.rs2[j]));
                    check($sformatf("%s.old_rd[%0d]", mon_e.name, j), 32'(bus.old_rd[j]), 32'(mon_e.old[j]));
                end
            end
            check({mon_e.name, ".ckpt_tag"}, 32'(bus.ckpt_tag), 32'(mon_e.tag));
            check({mon_e.name, ".ckpt_full"}, 32'(bus.ckpt_full), 32'(mon_e.full));
            check({mon_e.name, ".rename_ready"}, 32'(bus.rename_ready), 32'(mon_e.rdy));
        end
    end

    task automatic idle();
        bus.stall         = 1'b0;
        bus.valid_instr   = '0;
        bus.rs1           = '0;
        bus.rs2           = '0;
        bus.rd            = '0;
        bus.rd_we         = '0;
        bus.phys_rd       = '0;
        bus.ckpt_req      = '0;
        bus.resolve_valid = 1'b0;
        bus.resolve_tag   = '0;
        bus.recall_valid  = 1'b0;
        bus.recall_tag    = '0;
    endtask

    task automatic slot(input int k, input bit v, input bit we, input arch_reg_t rd,
                        input phys_reg_t prd, input arch_reg_t a, input arch_reg_t b, input bit ck);
        bus.valid_instr[k] = v;
        bus.rd_we[k]       = we;
        bus.rd[k]          = rd;
        bus.phys_rd[k]     = prd;
        bus.rs1[k]         = a;
        bus.rs2[k]         = b;
        bus.ckpt_req[k]    = ck;
    endtask

    task automatic exp_l(input string nm, input phys_reg_t a0, input phys_reg_t a1,
                         input phys_reg_t b0, input phys_reg_t b1, input phys_reg_t o0,
                         input phys_reg_t o1, input ckpt_tag_t t, input bit f, input bit r);
        exp_t e;
        e.name = nm; e.chk_lookup = 1'b1;
        e.rs1[0] = a0; e.rs1[1] = a1;
        e.rs2[0] = b0; e.rs2[1] = b1;
        e.old[0] = o0; e.old[1] = o1;
        e.tag = t; e.full = f; e.rdy = r;
        exp_q.push_back(e);
    endtask

    task automatic exp_s(input string nm, input ckpt_tag_t t, input bit f, input bit r);
        exp_t e;
        e.name = nm; e.chk_lookup = 1'b0;
        e.rs1 = '0; e.rs2 = '0; e.old = '0;
        e.tag = t; e.full = f; e.rdy = r;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset map is identity
        idle(); slot(0,0,0,0,0,5,31,0); slot(1,0,0,2,0,0,1,0);
        exp_l("reset", 5,0, 31,1, 0,2, 0,0,1); tick();
        // Same-group bypass, youngest writer wins in the map
        idle(); slot(0,1,1,3,40,3,4,0); slot(1,1,1,3,41,3,3,0);
        exp_l("bypass", 3,40, 4,40, 3,40, 0,0,1); tick();
        // x0 write is dropped and not bypassed
        idle(); slot(0,1,1,0,50,3,2,0); slot(1,1,0,3,0,0,3,0);
        exp_l("x0_write", 41,0, 2,41, 0,41, 0,0,1); tick();
        idle(); slot(0,0,0,0,0,0,0,0); slot(1,0,0,0,0,0,7,0);
        exp_l("x0_read", 0,0, 0,7, 0,0, 0,0,1); tick();

        // Four checkpoints fill the ring
        idle(); slot(0,1,1,7,42,7,3,1); slot(1,1,1,7,43,7,0,0);
        exp_l("ckpt0", 7,42, 41,0, 7,42, 0,0,1); tick();
        idle(); slot(0,1,1,8,44,7,8,0); slot(1,1,1,9,45,8,9,1);
        exp_l("ckpt1", 43,44, 8,9, 8,9, 1,0,1); tick();
        idle(); slot(0,1,0,10,0,9,10,1); slot(1,0,0,0,0,10,9,0);
        exp_l("ckpt2", 45,10, 10,45, 10,0, 2,0,1); tick();
        idle(); slot(0,0,0,0,0,1,2,0); slot(1,1,0,0,0,3,7,1);
        exp_l("ckpt3", 1,41, 2,43, 0,0, 3,0,1); tick();
        idle(); slot(0,1,1,7,60,7,0,1); slot(1,0,0,0,0,7,0,0);
        exp_l("ckpt_over", 43,60, 0,0, 43,0, 0,1,0); tick();
        idle(); slot(0,0,0,0,0,7,8,0); slot(1,0,0,0,0,0,0,0);
        exp_l("no_change", 43,0, 44,0, 0,0, 0,1,1); tick();
        idle(); bus.recall_valid = 1'b1; bus.recall_tag = 2'd0;
        slot(0,1,1,5,61,5,0,0); slot(1,0,0,0,0,5,0,0);
        exp_l("recall0", 5,61, 0,0, 5,0, 0,1,0); tick();
        idle(); slot(0,0,0,5,0,7,8,0); slot(1,0,0,0,0,9,3,0);
        exp_l("after_recall0", 42,9, 8,41, 5,0, 0,0,1); tick();

        // Resolve out of order, in-order retirement, recall of a younger tag
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("c0", 0,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("c1", 1,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("c2", 2,0,1); tick();
        idle(); slot(0,1,1,12,50,12,0,1); slot(1,1,1,13,51,13,12,0);
        exp_l("c3", 12,13, 0,50, 12,13, 3,0,1); tick();
        idle(); bus.stall = 1'b1; slot(0,1,1,20,59,20,0,0);
        exp_s("stall", 0,1,1); tick();
        idle(); slot(0,1,1,12,52,20,0,0);
        exp_l("write_full", 20,0, 0,0, 50,0, 0,1,1); tick();
        idle(); bus.resolve_valid = 1'b1; bus.resolve_tag = 2'd1;
        exp_s("res1", 0,1,1); tick();
        idle(); bus.resolve_valid = 1'b1; bus.resolve_tag = 2'd0;
        exp_s("res0", 0,1,1); tick();
        idle(); exp_s("retire0", 0,1,1); tick();
        idle(); exp_s("retire1", 0,0,1); tick();
        idle(); bus.recall_valid = 1'b1; bus.recall_tag = 2'd3;
        exp_s("recall3", 0,0,0); tick();
        idle(); slot(0,0,0,12,0,12,13,0); slot(1,0,0,0,0,3,7,0);
        exp_l("after_recall3", 50,41, 13,42, 50,0, 3,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("a1", 3,0,1); tick();
        idle(); slot(0,1,1,14,56,0,0,1); exp_s("a2", 0,0,1); tick();
        idle(); slot(0,1,1,15,57,0,0,1); exp_s("a3", 1,0,1); tick();
        idle(); slot(0,1,1,14,58,14,15,0);
        exp_l("full_again", 56,0, 57,0, 56,0, 2,1,1); tick();

        // Recall with a resolve of a discarded tag and a live rename group
        idle(); bus.recall_valid = 1'b1; bus.recall_tag = 2'd0;
        bus.resolve_valid = 1'b1; bus.resolve_tag = 2'd1;
        slot(0,1,1,20,55,20,14,0); slot(1,1,0,0,0,20,0,0);
        exp_l("recall_resolve", 20,55, 58,0, 20,0, 2,1,0); tick();
        idle(); slot(0,0,0,20,0,14,15,0); slot(1,0,0,12,0,20,7,0);
        exp_l("after_rr", 56,20, 15,42, 20,50, 0,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("b1", 0,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("b2", 1,0,1); tick();
        idle(); slot(0,1,0,0,0,0,0,1); exp_s("b_full", 2,1,0); tick();
        idle(); tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
